// File: rtl/pool_window_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pool_window_ctrl_pkg
//   Definitions shared by the 2x2 max-pooling window controller:
//     - state_t          : controller FSM state encoding
//     - *_DEFAULT        : default pixel / index widths
//     - pool_dim()       : pooled dimension for a stride-2 2x2 window (floor)
// -----------------------------------------------------------------------------
package pool_window_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    OUT  = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam int DATA_W_DEFAULT  = 8;
  localparam int ADDR_W_DEFAULT  = 10;
  localparam int OADDR_W_DEFAULT = 8;

  // Number of complete 2x2 windows along one axis; an odd trailing
  // row/column has no partner and is dropped.
  function automatic int pool_dim(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/pool_window_ctrl_max4.sv
// -----------------------------------------------------------------------------
// max4_signed
//   Combinational signed maximum of four DATA_W-bit values, built as a
//   two-level comparator tree (two pairwise compares, then one final compare).
//   Ties select the equal value, so any tie resolves to the same result.
//
//   Ports
//     in0..in3 : signed DATA_W operands
//     max_out  : signed DATA_W maximum
// -----------------------------------------------------------------------------
module max4_signed
  import pool_window_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic signed [DATA_W-1:0] in0,
  input  logic signed [DATA_W-1:0] in1,
  input  logic signed [DATA_W-1:0] in2,
  input  logic signed [DATA_W-1:0] in3,
  output logic signed [DATA_W-1:0] max_out
);

  logic signed [DATA_W-1:0] lvl0 [4];
  logic signed [DATA_W-1:0] lvl1 [2];

  assign lvl0[0] = in0;
  assign lvl0[1] = in1;
  assign lvl0[2] = in2;
  assign lvl0[3] = in3;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lvl1
      assign lvl1[gi] = (lvl0[2*gi] >= lvl0[2*gi+1]) ? lvl0[2*gi] : lvl0[2*gi+1];
    end
  endgenerate

  assign max_out = (lvl1[0] >= lvl1[1]) ? lvl1[0] : lvl1[1];

endmodule

// File: rtl/pool_window_ctrl.sv
// -----------------------------------------------------------------------------
// pool_window_ctrl
//   Walks a N_R x N_C conv-result image in 2x2 windows (stride 2), reads each
//   window from a one-cycle-latency memory, and emits the signed maximum with
//   its row-major pooled index over a valid/ready output.
//
//   Per window: RD (issue read) -> CAP (capture max) -> OUT (hold until
//   accepted). FIN pulses done for one cycle after the last window.
//
//   Ports
//     clk, rst_n              : clock, asynchronous active-low reset
//     start                   : begin one pass (only honoured in IDLE)
//     busy, done              : pass in progress / one-cycle completion pulse
//     mem_ren                 : memory read enable (one cycle per window)
//     mem_radd1, mem_radd2    : window top-left row / column
//     mem_rdata0..3           : pixels (r,c) (r,c+1) (r+1,c) (r+1,c+1),
//                               valid one cycle after mem_ren
//     out_valid, out_ready    : output handshake
//     out_data, out_addr      : pooled maximum / row-major pooled index
// -----------------------------------------------------------------------------
module pool_window_ctrl
  import pool_window_ctrl_pkg::*;
#(
  parameter int N_C     = 26,
  parameter int N_R     = 26,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int OADDR_W = OADDR_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_ren,
  output logic [ADDR_W-1:0]         mem_radd1,
  output logic [ADDR_W-1:0]         mem_radd2,
  input  logic signed [DATA_W-1:0]  mem_rdata0,
  input  logic signed [DATA_W-1:0]  mem_rdata1,
  input  logic signed [DATA_W-1:0]  mem_rdata2,
  input  logic signed [DATA_W-1:0]  mem_rdata3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_data,
  output logic [OADDR_W-1:0]        out_addr
);

  localparam int PR = pool_dim(N_R);
  localparam int PC = pool_dim(N_C);

  // An image smaller than 2x2 has no windows: a pass goes straight to FIN.
  localparam bit EMPTY = (PR == 0) || (PC == 0);

  localparam logic [ADDR_W-1:0] PR_LAST = EMPTY ? '0 : ADDR_W'(PR - 1);
  localparam logic [ADDR_W-1:0] PC_LAST = EMPTY ? '0 : ADDR_W'(PC - 1);

  state_t                   state_reg, state_next;
  logic [ADDR_W-1:0]        prow_reg, prow_next;
  logic [ADDR_W-1:0]        pcol_reg, pcol_next;

  logic                     busy_reg;
  logic                     done_reg;
  logic                     mem_ren_reg;
  logic                     out_valid_reg;
  logic [ADDR_W-1:0]        mem_radd1_reg;
  logic [ADDR_W-1:0]        mem_radd2_reg;
  logic signed [DATA_W-1:0] out_data_reg;
  logic [OADDR_W-1:0]       out_addr_reg;

  logic signed [DATA_W-1:0] window_max;
  logic [OADDR_W-1:0]       window_addr;

  max4_signed #(
    .DATA_W (DATA_W)
  ) u_max4 (
    .in0     (mem_rdata0),
    .in1     (mem_rdata1),
    .in2     (mem_rdata2),
    .in3     (mem_rdata3),
    .max_out (window_max)
  );

  assign window_addr = OADDR_W'(prow_reg) * OADDR_W'(PC) + OADDR_W'(pcol_reg);

  // Next-state and counter logic
  always_comb begin
    state_next = state_reg;
    prow_next  = prow_reg;
    pcol_next  = pcol_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          prow_next  = '0;
          pcol_next  = '0;
          state_next = EMPTY ? FIN : RD;
        end
      end

      RD:  state_next = CAP;

      CAP: state_next = OUT;

      OUT: begin
        if (out_ready) begin
          if (pcol_reg != PC_LAST) begin
            pcol_next = pcol_reg + 1'b1;
          end else begin
            pcol_next = '0;
            prow_next = prow_reg + 1'b1;
          end
          state_next = ((prow_reg == PR_LAST) && (pcol_reg == PC_LAST)) ? FIN : RD;
        end
      end

      FIN:     state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every status
  // output lines up with the state it describes and resets cleanly to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      prow_reg      <= '0;
      pcol_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mem_ren_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      mem_radd1_reg <= '0;
      mem_radd2_reg <= '0;
      out_data_reg  <= '0;
      out_addr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      prow_reg      <= prow_next;
      pcol_reg      <= pcol_next;
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == FIN);
      mem_ren_reg   <= (state_next == RD);
      out_valid_reg <= (state_next == OUT);

      // Window origin is twice the pooled coordinate; held between reads.
      if (state_next == RD) begin
        mem_radd1_reg <= {prow_next[ADDR_W-2:0], 1'b0};
        mem_radd2_reg <= {pcol_next[ADDR_W-2:0], 1'b0};
      end

      // Read data arrives during CAP (one cycle after the RD enable).
      if (state_reg == CAP) begin
        out_data_reg <= window_max;
        out_addr_reg <= window_addr;
      end
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign mem_ren   = mem_ren_reg;
  assign out_valid = out_valid_reg;
  assign mem_radd1 = mem_radd1_reg;
  assign mem_radd2 = mem_radd2_reg;
  assign out_data  = out_data_reg;
  assign out_addr  = out_addr_reg;

endmodule

// File: tb/tb_pool_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pool_window_ctrl
//   Two instances (26x26 and 5x5) share one clock and reset. A behavioural
//   memory feeds each; the expected output stream is computed directly from
//   the image contents with plain loops.
// -----------------------------------------------------------------------------
module tb_pool_window_ctrl;

  localparam int NB = 26;
  localparam int NS = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start26 = 1'b0;
  logic start5 = 1'b0;
  logic out_ready = 1'b0;

  logic              busy26, done26, ren26, v26;
  logic [9:0]        ra1_26, ra2_26;
  logic signed [7:0] d0_26 = 0, d1_26 = 0, d2_26 = 0, d3_26 = 0;
  logic signed [7:0] od26;
  logic [7:0]        oa26;

  logic              busy5, done5, ren5, v5;
  logic [9:0]        ra1_5, ra2_5;
  logic signed [7:0] d0_5 = 0, d1_5 = 0, d2_5 = 0, d3_5 = 0;
  logic signed [7:0] od5;
  logic [7:0]        oa5;

  logic signed [7:0] img26 [0:NB-1][0:NB-1];
  logic signed [7:0] img5  [0:NS-1][0:NS-1];
  int oob26 = 0;
  int oob5  = 0;

  int checks = 0;
  int errors = 0;

  int exp_addr[$];
  int exp_data[$];

  bit sel5 = 1'b0;

  always #5 clk = ~clk;

  pool_window_ctrl #(.N_C(NB), .N_R(NB), .ADDR_W(10), .DATA_W(8), .OADDR_W(8)) dut26 (
    .clk(clk), .rst_n(rst_n), .start(start26), .busy(busy26), .done(done26),
    .mem_ren(ren26), .mem_radd1(ra1_26), .mem_radd2(ra2_26),
    .mem_rdata0(d0_26), .mem_rdata1(d1_26), .mem_rdata2(d2_26), .mem_rdata3(d3_26),
    .out_valid(v26), .out_ready(out_ready), .out_data(od26), .out_addr(oa26)
  );

  pool_window_ctrl #(.N_C(NS), .N_R(NS), .ADDR_W(10), .DATA_W(8), .OADDR_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .busy(busy5), .done(done5),
    .mem_ren(ren5), .mem_radd1(ra1_5), .mem_radd2(ra2_5),
    .mem_rdata0(d0_5), .mem_rdata1(d1_5), .mem_rdata2(d2_5), .mem_rdata3(d3_5),
    .out_valid(v5), .out_ready(out_ready), .out_data(od5), .out_addr(oa5)
  );

  // One-cycle-latency memories; any read reaching past the last full window
  // (e.g. row/column 4 of the 5x5 image) is counted as out of bounds.
  always @(posedge clk) begin
    if (ren26) begin
      if (int'(ra1_26) + 1 >= 2 * (NB / 2) || int'(ra2_26) + 1 >= 2 * (NB / 2)) oob26++;
      else begin
        d0_26 <= img26[ra1_26][ra2_26];
        d1_26 <= img26[ra1_26][ra2_26 + 1];
        d2_26 <= img26[ra1_26 + 1][ra2_26];
        d3_26 <= img26[ra1_26 + 1][ra2_26 + 1];
      end
    end
    if (ren5) begin
      if (int'(ra1_5) + 1 >= 2 * (NS / 2) || int'(ra2_5) + 1 >= 2 * (NS / 2)) oob5++;
      else begin
        d0_5 <= img5[ra1_5][ra2_5];
        d1_5 <= img5[ra1_5][ra2_5 + 1];
        d2_5 <= img5[ra1_5 + 1][ra2_5];
        d3_5 <= img5[ra1_5 + 1][ra2_5 + 1];
      end
    end
  end

  logic              o_busy, o_done, o_ren, o_valid;
  logic [9:0]        o_ra1, o_ra2;
  logic signed [7:0] o_data;
  logic [7:0]        o_addr;

  assign o_busy  = sel5 ? busy5 : busy26;
  assign o_done  = sel5 ? done5 : done26;
  assign o_ren   = sel5 ? ren5  : ren26;
  assign o_valid = sel5 ? v5    : v26;
  assign o_ra1   = sel5 ? ra1_5 : ra1_26;
  assign o_ra2   = sel5 ? ra2_5 : ra2_26;
  assign o_data  = sel5 ? od5   : od26;
  assign o_addr  = sel5 ? oa5   : oa26;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input bit s5, input int r, input int c);
    return s5 ? int'(img5[r][c]) : int'(img26[r][c]);
  endfunction

  // Reference: for every complete 2x2 window, the largest of its four pixels.
  task automatic build_model(input bit s5);
    int n, m, v;
    n = s5 ? NS : NB;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n / 2; i++) begin
      for (int j = 0; j < n / 2; j++) begin
        m = pix(s5, 2 * i, 2 * j);
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            v = pix(s5, 2 * i + dr, 2 * j + dc);
            if (v > m) m = v;
          end
        exp_addr.push_back(i * (n / 2) + j);
        exp_data.push_back(m);
      end
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < NB; r++)
      for (int c = 0; c < NB; c++) img26[r][c] = 8'(r + c - 40);
  endtask

  task automatic build_ramp_expect();
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < NB / 2; i++)
      for (int j = 0; j < NB / 2; j++) begin
        exp_addr.push_back(i * (NB / 2) + j);
        exp_data.push_back(2 * i + 2 * j - 38);
      end
  endtask

  task automatic fill_random26();
    for (int r = 0; r < NB; r++)
      for (int c = 0; c < NB; c++) img26[r][c] = 8'($urandom);
  endtask

  // mode 0: ready high (timing checked), 1: random ready, 2: 10-cycle stall at output 7
  task automatic run_pass(input bit s5, input int mode, input bit spam, input string tag);
    int cyc, k, dones, done_cyc, stall;
    logic signed [7:0] cap_d;
    logic [7:0] cap_a;
    bit rdy;
    cyc = 0; k = 0; dones = 0; done_cyc = 0; stall = 0; cap_d = 0; cap_a = 0;
    sel5 = s5;
    @(negedge clk);
    if (s5) start5 = 1'b1; else start26 = 1'b1;
    @(posedge clk);
    while (dones == 0 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (spam) begin
        start26 = s5 ? 1'b0 : 1'($urandom_range(0, 1));
        start5  = s5 ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        start26 = 1'b0;
        start5  = 1'b0;
      end
      chk({tag, "_busy"}, o_busy, 1);
      rdy = 1'b1;
      if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && o_valid && k == 7 && stall < 10) begin
        rdy = 1'b0;
        if (stall == 0) begin
          cap_d = o_data;
          cap_a = o_addr;
        end else begin
          chk({tag, "_stall_valid"}, o_valid, 1);
          chk({tag, "_stall_data"}, o_data, cap_d);
          chk({tag, "_stall_addr"}, o_addr, cap_a);
        end
        chk({tag, "_stall_ren"}, o_ren, 0);
        stall++;
      end
      out_ready = rdy;
      if (o_valid) chk({tag, "_ren_in_out"}, o_ren, 0);
      if (o_valid && rdy) begin
        if (k < exp_addr.size()) begin
          chk({tag, "_addr"}, o_addr, exp_addr[k]);
          chk({tag, "_data"}, o_data, exp_data[k]);
        end else begin
          chk({tag, "_extra_output"}, k, exp_addr.size());
        end
        if (mode == 0) chk({tag, "_out_timing"}, cyc, 3 * k + 3);
        k++;
      end
      if (o_done) begin
        dones++;
        done_cyc = cyc;
      end
    end
    chk({tag, "_count"}, k, exp_addr.size());
    chk({tag, "_done_seen"}, dones, 1);
    if (mode == 2) chk({tag, "_stall_len"}, stall, 10);
    if (mode == 0) chk({tag, "_done_timing"}, done_cyc, 3 * exp_addr.size() + 1);
    // start raised during FIN must not launch another pass
    if (s5) start5 = 1'b1; else start26 = 1'b1;
    @(negedge clk);
    start26 = 1'b0;
    start5  = 1'b0;
    chk({tag, "_done_width"}, o_done, 0);
    chk({tag, "_idle_after_fin"}, o_busy, 0);
    $display("pass %s: outputs=%0d cycles_to_done=%0d", tag, k, done_cyc);
  endtask

  initial begin
    int cnt;
    bit found;

    // Reset state
    sel5 = 1'b0;
    #12;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ren", o_ren, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_ra1", o_ra1, 0);
    chk("rst_ra2", o_ra2, 0);
    chk("rst_data", o_data, 0);
    chk("rst_addr", o_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", o_busy, 0);

    // Ramp image: closed-form expectations
    fill_ramp();
    build_ramp_expect();
    run_pass(1'b0, 0, 1'b0, "ramp");

    // Random image with signed-extreme windows at (0,0) and (0,1), random ready
    fill_random26();
    img26[0][0] = -128; img26[0][1] = -5;   img26[1][0] = -128; img26[1][1] = -128;
    img26[0][2] = -128; img26[0][3] = -128; img26[1][2] = -128; img26[1][3] = -128;
    img26[2][0] = 127;  img26[2][1] = 127;  img26[3][0] = -1;   img26[3][1] = 127;
    build_model(1'b0);
    chk("model_neg5", exp_data[0], -5);
    chk("model_all_min", exp_data[1], -128);
    run_pass(1'b0, 1, 1'b0, "rand_ready");

    // Back-pressure stall at output 7
    run_pass(1'b0, 2, 1'b0, "stall");

    // start pulsed throughout the pass
    fill_random26();
    build_model(1'b0);
    run_pass(1'b0, 0, 1'b1, "spam_start");

    // Reset during OUT of output 50
    fill_ramp();
    build_ramp_expect();
    sel5 = 1'b0;
    @(negedge clk);
    start26 = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start26 = 1'b0;
    cnt = 0;
    found = 1'b0;
    while (!found && cnt < 2000) begin
      if (o_valid && o_addr == 8'd50) found = 1'b1;
      else begin
        @(negedge clk);
        cnt++;
      end
    end
    chk("rst_mid_reached", found, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_done", o_done, 0);
    chk("rst_mid_ren", o_ren, 0);
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_ra1", o_ra1, 0);
    chk("rst_mid_ra2", o_ra2, 0);
    chk("rst_mid_data", o_data, 0);
    chk("rst_mid_addr", o_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", o_busy, 0);
      chk("post_rst_no_done", o_done, 0);
    end
    run_pass(1'b0, 0, 1'b0, "restart");

    // 5x5 image: odd last row/column skipped
    for (int r = 0; r < NS; r++)
      for (int c = 0; c < NS; c++) img5[r][c] = 8'($urandom);
    img5[4][0] = 127; img5[0][4] = 127; img5[4][4] = 127;
    build_model(1'b1);
    run_pass(1'b1, 0, 1'b0, "n5");
    chk("n5_no_oob", oob5, 0);
    chk("n26_no_oob", oob26, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
